// File: rtl/pe_array_os_if.sv
// Operand/result handshake bundle for pe_array_os.
// master = surrounding datapath (operand buffers + score stage), slave = the array.
interface pe_array_os_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 16
);
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [ROWS*DW-1:0]      in_act;
    logic [COLS*DW-1:0]      in_wgt;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*DW-1:0]      out_data;
    logic [$clog2(ROWS)-1:0] out_row;
    logic                    out_last;
    logic                    out_sat;

    modport master (
        output clear, in_valid, in_last, in_act, in_wgt, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last, out_sat
    );

    modport slave (
        input  clear, in_valid, in_last, in_act, in_wgt, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last, out_sat
    );
endinterface

// File: rtl/pe_array_os.sv
// Output-stationary ROWS x COLS systolic MAC array with skewed operand entry and a row-wise drain.
// Define PE_ARRAY_SAT_EN to clamp drained results to the signed DW range (else low DW bits are kept).
module pe_array_os #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 16,
    parameter int AW   = 36,
    parameter int FRAC = 0
) (
    input logic          clk,
    input logic          rst_n,
    pe_array_os_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS + COLS - 1);

    typedef enum logic [1:0] {LOAD, FLUSH, DRAIN} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_flushCnt;
    logic                 r_outValid;
    logic                 r_outLast;
    logic [RW-1:0]        r_outRow;
    logic signed [AW-1:0] r_rowData [COLS];

    logic                 w_accept;
    logic                 w_drainHs;
    logic                 w_zeroAcc;
    logic [RW-1:0]        w_nextRow;

    assign w_accept  = (r_state == LOAD) && bus.in_valid;
    assign w_drainHs = r_outValid && bus.out_ready;
    assign w_zeroAcc = bus.clear || (w_drainHs && r_outLast);
    assign w_nextRow = r_outRow + RW'(1);

    // Operands only enter while loading; every other cycle pushes zeros into the wavefront.
    logic signed [DW-1:0] w_actInj [ROWS];
    logic signed [DW-1:0] w_wgtInj [COLS];

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            w_actInj[i] = w_accept ? bus.in_act[i*DW +: DW] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            w_wgtInj[j] = w_accept ? bus.in_wgt[j*DW +: DW] : '0;
        end
    end

    logic signed [DW-1:0] w_actSkew [ROWS];
    logic signed [DW-1:0] w_wgtSkew [COLS];

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_actSkew
            if (gi == 0) begin : g_direct
                assign w_actSkew[gi] = w_actInj[gi];
            end else begin : g_line
                logic signed [DW-1:0] r_line [gi];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int d = 0; d < gi; d++) r_line[d] <= '0;
                    end else if (bus.clear) begin
                        for (int d = 0; d < gi; d++) r_line[d] <= '0;
                    end else begin
                        r_line[0] <= w_actInj[gi];
                        for (int d = 1; d < gi; d++) r_line[d] <= r_line[d-1];
                    end
                end
                assign w_actSkew[gi] = r_line[gi-1];
            end
        end

        for (gi = 0; gi < COLS; gi++) begin : g_wgtSkew
            if (gi == 0) begin : g_direct
                assign w_wgtSkew[gi] = w_wgtInj[gi];
            end else begin : g_line
                logic signed [DW-1:0] r_line [gi];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int d = 0; d < gi; d++) r_line[d] <= '0;
                    end else if (bus.clear) begin
                        for (int d = 0; d < gi; d++) r_line[d] <= '0;
                    end else begin
                        r_line[0] <= w_wgtInj[gi];
                        for (int d = 1; d < gi; d++) r_line[d] <= r_line[d-1];
                    end
                end
                assign w_wgtSkew[gi] = r_line[gi-1];
            end
        end
    endgenerate

    // PE grid: activations hop right one column per cycle, weights hop down one row per cycle.
    logic signed [DW-1:0]   w_actIn   [ROWS][COLS];
    logic signed [DW-1:0]   w_wgtIn   [ROWS][COLS];
    logic signed [2*DW-1:0] w_prod    [ROWS][COLS];
    logic signed [DW-1:0]   r_actPipe [ROWS][COLS-1];
    logic signed [DW-1:0]   r_wgtPipe [ROWS-1][COLS];
    logic signed [AW-1:0]   r_acc     [ROWS][COLS];

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            w_actIn[i][0] = w_actSkew[i];
            for (int j = 1; j < COLS; j++) begin
                w_actIn[i][j] = r_actPipe[i][j-1];
            end
        end
        for (int j = 0; j < COLS; j++) begin
            w_wgtIn[0][j] = w_wgtSkew[j];
            for (int i = 1; i < ROWS; i++) begin
                w_wgtIn[i][j] = r_wgtPipe[i-1][j];
            end
        end
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                w_prod[i][j] = (2*DW)'(w_actIn[i][j]) * (2*DW)'(w_wgtIn[i][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS - 1; j++) r_actPipe[i][j] <= '0;
            end
            for (int i = 0; i < ROWS - 1; i++) begin
                for (int j = 0; j < COLS; j++) r_wgtPipe[i][j] <= '0;
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) r_acc[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS - 1; j++) begin
                    r_actPipe[i][j] <= bus.clear ? '0 : w_actIn[i][j];
                end
            end
            for (int i = 0; i < ROWS - 1; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    r_wgtPipe[i][j] <= bus.clear ? '0 : w_wgtIn[i][j];
                end
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    r_acc[i][j] <= w_zeroAcc ? '0 : r_acc[i][j] + AW'(w_prod[i][j]);
                end
            end
        end
    end

    // Flush waits for the last product to reach PE(ROWS-1,COLS-1); drain then latches one row per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_flushCnt <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outRow   <= '0;
            for (int j = 0; j < COLS; j++) r_rowData[j] <= '0;
        end else if (bus.clear) begin
            r_state    <= LOAD;
            r_flushCnt <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outRow   <= '0;
            for (int j = 0; j < COLS; j++) r_rowData[j] <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept && bus.in_last) begin
                        r_state    <= FLUSH;
                        r_flushCnt <= CW'(ROWS + COLS - 2);
                    end
                end
                FLUSH: begin
                    if (r_flushCnt == '0) begin
                        r_state    <= DRAIN;
                        r_outValid <= 1'b1;
                        r_outLast  <= 1'b0;
                        r_outRow   <= '0;
                        for (int j = 0; j < COLS; j++) r_rowData[j] <= r_acc[0][j];
                    end else begin
                        r_flushCnt <= r_flushCnt - CW'(1);
                    end
                end
                DRAIN: begin
                    if (w_drainHs) begin
                        if (r_outLast) begin
                            r_state    <= LOAD;
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                            r_outRow   <= '0;
                            for (int j = 0; j < COLS; j++) r_rowData[j] <= '0;
                        end else begin
                            r_outRow  <= w_nextRow;
                            r_outLast <= (w_nextRow == RW'(ROWS - 1));
                            for (int j = 0; j < COLS; j++) r_rowData[j] <= r_acc[w_nextRow][j];
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    logic [COLS*DW-1:0] w_outData;

`ifdef PE_ARRAY_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0] w_shifted [COLS];
    logic [COLS-1:0]      w_clip;

    always_comb begin
        w_outData = '0;
        w_clip    = '0;
        for (int j = 0; j < COLS; j++) begin
            w_shifted[j] = r_rowData[j] >>> FRAC;
            if (w_shifted[j] > SAT_MAX) begin
                w_outData[j*DW +: DW] = SAT_MAX[DW-1:0];
                w_clip[j]             = 1'b1;
            end else if (w_shifted[j] < SAT_MIN) begin
                w_outData[j*DW +: DW] = SAT_MIN[DW-1:0];
                w_clip[j]             = 1'b1;
            end else begin
                w_outData[j*DW +: DW] = w_shifted[j][DW-1:0];
            end
        end
    end

    assign bus.out_sat = |w_clip;
`else
    always_comb begin
        w_outData = '0;
        for (int j = 0; j < COLS; j++) begin
            w_outData[j*DW +: DW] = DW'(r_rowData[j] >>> FRAC);
        end
    end

    assign bus.out_sat = 1'b0;
`endif

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = r_outValid;
    assign bus.out_last  = r_outLast;
    assign bus.out_row   = r_outRow;
    assign bus.out_data  = w_outData;

endmodule

// File: tb/tb_pe_array_os.sv
// Self-checking bench for pe_array_os: scoreboarded 8x8 tiles plus a 2x2 FRAC=8 instance.
// Expectations follow PE_ARRAY_SAT_EN when it is defined for the build.
module tb_pe_array_os;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 16;

    typedef struct {
        logic [COLS*DW-1:0] data;
        int                 row;
        bit                 last;
        bit                 sat;
    } exp_t;

    typedef struct {
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expLane;
        bit          expSat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pe_array_os_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus ();
    pe_array_os_if #(.ROWS(2), .COLS(2), .DW(DW)) bus2 ();

    pe_array_os #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(36), .FRAC(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    pe_array_os #(.ROWS(2), .COLS(2), .DW(DW), .AW(36), .FRAC(8)) dutFrac (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int   checks = 0;
    int   errors = 0;
    int   hsCount = 0;
    bit   pendReady = 0;
    exp_t sbq[$];
    int   tK;
    int   tA [ROWS][16];
    int   tB [16][COLS];
    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic buildIdentity();
        tK = 8;
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 16; k++) tA[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < COLS; j++) tB[k][j] = k + 1;
    endtask

    task automatic buildUniform(input int k, input logic [15:0] a, input logic [15:0] b);
        tK = k;
        for (int i = 0; i < ROWS; i++)
            for (int kk = 0; kk < 16; kk++) tA[i][kk] = int'($signed(a));
        for (int kk = 0; kk < 16; kk++)
            for (int j = 0; j < COLS; j++) tB[kk][j] = int'($signed(b));
    endtask

    // Reference: plain matrix product, 36-bit wrap, then narrowing at FRAC=0.
    task automatic pushModel();
        for (int i = 0; i < ROWS; i++) begin
            exp_t e;
            e.data = '0;
            e.sat  = 1'b0;
            e.row  = i;
            e.last = (i == ROWS - 1);
            for (int j = 0; j < COLS; j++) begin
                longint      s = 0;
                logic [63:0] sv;
                for (int k = 0; k < tK; k++) s += longint'(tA[i][k]) * longint'(tB[k][j]);
                s = (s <<< 28) >>> 28;
                sv = s;
`ifdef PE_ARRAY_SAT_EN
                if (s > 32767) begin
                    sv = 64'h7FFF;
                    e.sat = 1'b1;
                end else if (s < -32768) begin
                    sv = 64'h8000;
                    e.sat = 1'b1;
                end
`endif
                e.data[j*DW +: DW] = sv[15:0];
            end
            sbq.push_back(e);
        end
    endtask

    task automatic pushUniform(input logic [15:0] lane, input bit sat);
        for (int i = 0; i < ROWS; i++) begin
            exp_t e;
            e.data = {COLS{lane}};
            e.row  = i;
            e.last = (i == ROWS - 1);
            e.sat  = sat;
            sbq.push_back(e);
        end
    endtask

    task automatic applyStimulus();
        int n;
        for (int k = 0; k < tK; k++) begin
            n = 0;
            while (!bus.in_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!bus.in_ready) failNow("in_ready_wait");
            for (int i = 0; i < ROWS; i++) bus.in_act[i*DW +: DW] = 16'(tA[i][k]);
            for (int j = 0; j < COLS; j++) bus.in_wgt[j*DW +: DW] = 16'(tB[k][j]);
            bus.in_valid = 1'b1;
            bus.in_last  = (k == tK - 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_act   = '0;
        bus.in_wgt   = '0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("first_row_latency", n, ROWS + COLS - 1);
    endtask

    task automatic waitIdle(input bit backpressure);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n = 0;
        while (!(bus.in_ready && sbq.size() == 0) && n < 400) begin
            if (backpressure) bus.out_ready = pat[n % 4];
            @(posedge clk); #1;
            n++;
        end
        bus.out_ready = 1'b1;
        if (!(bus.in_ready && sbq.size() == 0)) begin
            failNow("drain_wait");
            sbq.delete();
        end
    endtask

    task automatic waitRow3();
        int n = 0;
        while (!(bus.out_valid && bus.out_row == 3) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(bus.out_valid && bus.out_row == 3)) failNow("row3_wait");
    endtask

    // Scoreboard monitor, sampled mid-cycle; the head entry must match on every valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !bus.clear) begin
            if (pendReady) begin
                checkOutput("in_ready_after_last", bus.in_ready, 1);
                pendReady = 1'b0;
            end
            if (bus.out_valid) begin
                checkOutput("in_ready_in_drain", bus.in_ready, 0);
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_row", bus.out_row, 128'hDEAD);
                end else begin
                    e = sbq[0];
                    checkOutput("row_data", bus.out_data, e.data);
                    checkOutput("row_index", bus.out_row, e.row);
                    checkOutput("row_last", bus.out_last, e.last);
                    checkOutput("row_sat", bus.out_sat, e.sat);
                    if (bus.out_ready) begin
                        void'(sbq.pop_front());
                        hsCount++;
                        if (e.last) pendReady = 1'b1;
                    end
                end
            end
        end else begin
            pendReady = 1'b0;
        end
    end

    initial begin
        int hs0;
        int n;

        vecs[0] = '{1, 16'h0002, 16'hFFFD, 16'hFFFA, 1'b0};
        vecs[1] = '{3, 16'h0001, 16'h0001, 16'h0003, 1'b0};
        vecs[2] = '{2, 16'hFFFF, 16'hFFFF, 16'h0002, 1'b0};
        vecs[3] = '{1, 16'h8000, 16'h0001, 16'h8000, 1'b0};
`ifdef PE_ARRAY_SAT_EN
        vecs[4] = '{2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[5] = '{1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1};
        vecs[6] = '{4, 16'd100, 16'hFF38, 16'h8000, 1'b1};
`else
        vecs[4] = '{2, 16'h7FFF, 16'h7FFF, 16'h0002, 1'b0};
        vecs[5] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b0};
        vecs[6] = '{4, 16'd100, 16'hFF38, 16'hC780, 1'b0};
`endif

        rst_n = 1'b0;
        bus.clear = 1'b0;     bus.in_valid = 1'b0;  bus.in_last = 1'b0;
        bus.in_act = '0;      bus.in_wgt = '0;      bus.out_ready = 1'b1;
        bus2.clear = 1'b0;    bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        bus2.in_act = '0;     bus2.in_wgt = '0;     bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_out_last", bus.out_last, 0);
        checkOutput("reset_out_row", bus.out_row, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_out_sat", bus.out_sat, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] identity tile");
        buildIdentity();
        pushModel();
        applyStimulus();
        waitIdle(1'b0);

        $display("[TB] uniform vector table");
        for (int v = 0; v < 7; v++) begin
            buildUniform(vecs[v].k, vecs[v].a, vecs[v].b);
            pushUniform(vecs[v].expLane, vecs[v].expSat);
            applyStimulus();
            waitIdle(1'b0);
        end

        $display("[TB] identity tile with backpressure");
        hs0 = hsCount;
        buildIdentity();
        pushModel();
        applyStimulus();
        waitIdle(1'b1);
        checkOutput("bp_handshakes", hsCount - hs0, ROWS);

        $display("[TB] FRAC=8 instance");
        bus2.in_act   = {16'h0100, 16'h0100};
        bus2.in_wgt   = {16'h0300, 16'h0300};
        bus2.in_valid = 1'b1;
        bus2.in_last  = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        bus2.in_last  = 1'b0;
        n = 0;
        while (!bus2.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("frac_latency", n, 3);
        @(negedge clk);
        checkOutput("frac_row0_data", bus2.out_data, 32'h0300_0300);
        checkOutput("frac_row0_index", bus2.out_row, 0);
        checkOutput("frac_row0_last", bus2.out_last, 0);
        @(negedge clk);
        checkOutput("frac_row1_data", bus2.out_data, 32'h0300_0300);
        checkOutput("frac_row1_last", bus2.out_last, 1);
        checkOutput("frac_row1_sat", bus2.out_sat, 0);
        @(negedge clk);
        checkOutput("frac_done_valid", bus2.out_valid, 0);
        checkOutput("frac_done_in_ready", bus2.in_ready, 1);
        @(posedge clk); #1;

        $display("[TB] reset abort during drain");
        buildIdentity();
        pushModel();
        applyStimulus();
        waitRow3();
        sbq.delete();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_abort_out_valid", bus.out_valid, 0);
        checkOutput("rst_abort_out_row", bus.out_row, 0);
        checkOutput("rst_abort_out_data", bus.out_data, 0);
        checkOutput("rst_abort_out_last", bus.out_last, 0);
        checkOutput("rst_abort_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pushModel();
        applyStimulus();
        waitIdle(1'b0);

        $display("[TB] clear abort during drain");
        buildIdentity();
        pushModel();
        applyStimulus();
        waitRow3();
        sbq.delete();
        bus.clear = 1'b1;
        @(posedge clk); #1;
        checkOutput("clr_abort_out_valid", bus.out_valid, 0);
        checkOutput("clr_abort_out_row", bus.out_row, 0);
        checkOutput("clr_abort_in_ready", bus.in_ready, 1);
        bus.clear = 1'b0;
        @(posedge clk); #1;
        pushModel();
        applyStimulus();
        waitIdle(1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_array_os.md
# pe_array_os

Parametrised output-stationary systolic MAC array: the next generation of the fixed 8x8 attention PE cluster. It accepts one beat per k-step: a column of activations and a row of weights. Internal skew registers align the wavefronts, and a flush/drain state machine streams the ROWS x COLS result tile out one row per beat. Results are rescaled and narrowed on the way out. It sits between the Q/K operand buffers and the score/softmax stage.

## Interface
- ROWS, 8: array rows (activation lanes), >=2
- COLS, 8: array columns (weight lanes), >=2
- DW, 16: signed operand and output element width
- AW, 36: signed accumulator width, >= 2*DW
- FRAC, 0: arithmetic right shift applied at drain, 0..AW-DW
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort: empty skew lines, zero accumulators, go to LOAD
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in LOAD
- in_last  in  1  qualifies the final k-step of the tile
- in_act  in  ROWS*DW  lane i = A[i][k], bits [(i+1)*DW-1 : i*DW]
- in_wgt  in  COLS*DW  lane j = B[k][j]
- out_valid  out  1  result row valid (DRAIN)
- out_ready  in  1  downstream accepts row
- out_data  out  COLS*DW  narrowed C[out_row][j], lane j
- out_row  out  $clog2(ROWS)  row index being presented
- out_last  out  1  high with out_row == ROWS-1
- out_sat  out  1  any lane of current row clipped (0 when saturation compiled out)

## Operation
- States: LOAD, FLUSH, DRAIN.
- LOAD:
  - in_ready = 1.
  - On in_valid, lane i of in_act enters skew line i (depth i). Lane j of in_wgt enters skew line j (depth j).
  - Cycles without in_valid inject zeros into both skew lines.
  - An accepted beat with in_last loads the flush counter with ROWS+COLS-2 and moves to FLUSH.
- PE(i,j):
  - Activation passes right one register per column; weight passes down one register per row.
  - Every cycle: acc <= acc + sext_AW(act*wgt).
  - Signed DW x DW product, accumulation wraps modulo 2^AW.
- FLUSH:
  - in_ready = 0; zeros are injected.
  - Counter decrements each cycle; at 0 the block moves to DRAIN with out_row = 0.
- DRAIN:
  - out_valid = 1; out_data = narrow(acc[out_row][*] >>> FRAC).
  - out_row increments on out_valid && out_ready.
  - The handshake with out_last zeroes all accumulators and returns to LOAD.
  - out_ready low: out_data, out_row and out_sat hold stable.
- Narrowing: with saturation, clamp to [-2^(DW-1), 2^(DW-1)-1]; without, keep the low DW bits.
- in_valid outside LOAD is ignored; beats are not stored.
- clear has priority over all state activity. It takes effect at the next edge, and out_valid drops that edge.
- in_valid && in_last on the first beat (K=1) is legal.

## Timing
- Reset values:
  - state LOAD, in_ready 1 (combinational from state)
  - out_valid 0, out_last 0, out_row 0, out_data 0, out_sat 0
  - all accumulators and skew/pipe registers 0
- Last beat accepted at edge E0: DRAIN entered, and out_valid high, after edge E0+ROWS+COLS-1. For 8x8 this is 15 cycles.
- Minimum tile turnaround is K + ROWS+COLS-1 + ROWS cycles with out_ready held high.
- in_ready rises the cycle after the final drain handshake.
- out_data is driven from a registered row mux plus combinational narrowing; no extra latency.
- Reset asserted mid-FLUSH or mid-DRAIN discards the tile immediately.

## Configuration
- PE_ARRAY_SAT_EN defined:
  - Drain clamps each lane to the signed DW range.
  - out_sat = 1 if any lane in the presented row clipped.
- Undefined:
  - Truncation to the low DW bits, no clamp logic.
  - out_sat tied 0.

## Test plan
- Identity, 8x8, DW=16, FRAC=0, K=8: beat k has act lane k = 1 (others 0) and all wgt lanes = k+1 -> rows 0..7 read back all lanes = 1..8 respectively; out_last on row 7; out_valid first high 15 cycles after the last accept.
- K=1: act all 2, wgt all -3 in a single beat with in_last -> every lane -6, out_sat 0.
- Backpressure: identity tile, out_ready toggled 1,0,0,1... -> rows emitted in order 0..7, data stable while stalled, exactly 8 handshakes, in_ready 0 until after row 7.
- Saturation: K=2, all operands 0x7FFF, FRAC=0 -> acc 0x7FFE0002; with PE_ARRAY_SAT_EN out 0x7FFF and out_sat 1, without out 0x0002 and out_sat 0.
- FRAC=8, K=1, act 0x0100, wgt 0x0300 -> out 0x0300 every lane.
- Abort: rst_n low during DRAIN row 3, then a new identity tile -> outputs reset values immediately and the second tile is correct. Repeat the same with clear instead of rst_n.
